silife_display_framebuffer: RTL

//   Double-buffered snapshot of the cell grid, upstream of the MAX7219 display driver.
//   The Life engine writes rows into the back bank, then requests a swap.
//   The display driver reads rows combinationally from the front bank via its row select.

---
 rtl/silife_display_framebuffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/silife_display_framebuffer.sv
// Double-buffered cell-grid snapshot between the Life engine (writer) and the display driver.
// The writer fills the back bank; swaps wait for a display frame boundary so frames never tear.
module silife_display_framebuffer #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [$clog2(HEIGHT)-1:0]  i_wr_row,
    input  logic [WIDTH-1:0]           i_wr_cells,
    input  logic                       i_clear,
    input  logic                       i_swap_req,
    output logic                       o_swap_pending,
    output logic                       o_swap_done,
    input  logic                       i_display_en,
    input  logic [$clog2(HEIGHT)-1:0]  i_rd_row,
    output logic [WIDTH-1:0]           o_rd_cells,
    output logic                       o_front_bank
);
    localparam int ROW_BITS = $clog2(HEIGHT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic                  front_bank_reg, front_bank_next;
    logic                  swap_after_reg, swap_after_next;
    logic                  swap_done_reg, swap_done_next;
    logic [ROW_BITS-1:0]   clear_row_reg, clear_row_next;
    logic [ROW_BITS-1:0]   rd_row_q_reg;
    logic [WIDTH-1:0]      bank_reg [2][HEIGHT];

    logic                  wr_en;
    logic [ROW_BITS-1:0]   wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  back_bank;
    logic                  frame_sync;

    assign back_bank   = ~front_bank_reg;
    assign wr_in_range = {1'b0, wr_addr} < (ROW_BITS+1)'(HEIGHT);
    assign rd_in_range = {1'b0, i_rd_row} < (ROW_BITS+1)'(HEIGHT);
    // Driver disabled means no frame is being shown, so any cycle is a safe boundary.
    assign frame_sync  = !i_display_en || (i_rd_row == '0 && rd_row_q_reg != '0);

    always_comb begin
        o_rd_cells = '0;
        if (rd_in_range) begin
            o_rd_cells = bank_reg[front_bank_reg][i_rd_row];
        end
    end

    assign o_wr_ready     = (state_reg == IDLE);
    assign o_swap_pending = (state_reg == PENDING);
    assign o_swap_done    = swap_done_reg;
    assign o_front_bank   = front_bank_reg;

    always_comb begin
        state_next      = state_reg;
        front_bank_next = front_bank_reg;
        swap_after_next = swap_after_reg;
        clear_row_next  = clear_row_reg;
        swap_done_next  = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = i_wr_row;
        wr_data         = i_wr_cells;
        case (state_reg)
            IDLE: begin
                wr_en = i_wr_valid;
                if (i_clear) begin
                    state_next      = CLEAR;
                    clear_row_next  = '0;
                    swap_after_next = i_swap_req;
                end else if (i_swap_req) begin
                    state_next = PENDING;
                end
            end
            CLEAR: begin
                // The clear reuses the single write port, one row per cycle.
                wr_en          = 1'b1;
                wr_addr        = clear_row_reg;
                wr_data        = '0;
                clear_row_next = clear_row_reg + 1'b1;
                if (i_swap_req) begin
                    swap_after_next = 1'b1;
                end
                if (clear_row_reg == ROW_BITS'(HEIGHT - 1)) begin
                    state_next      = (swap_after_reg || i_swap_req) ? PENDING : IDLE;
                    swap_after_next = 1'b0;
                    clear_row_next  = '0;
                end
            end
            PENDING: begin
                if (frame_sync) begin
                    front_bank_next = ~front_bank_reg;
                    state_next      = IDLE;
                    swap_done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            front_bank_reg <= 1'b0;
            swap_after_reg <= 1'b0;
            swap_done_reg  <= 1'b0;
            clear_row_reg  <= '0;
            rd_row_q_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            front_bank_reg <= front_bank_next;
            swap_after_reg <= swap_after_next;
            swap_done_reg  <= swap_done_next;
            clear_row_reg  <= clear_row_next;
            rd_row_q_reg   <= i_rd_row;
        end
    end

    // Out-of-range rows are accepted by the handshake but never stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < HEIGHT; r++) begin
                    bank_reg[b][r] <= '0;
                end
            end
        end else if (wr_en && wr_in_range) begin
            bank_reg[back_bank][wr_addr] <= wr_data;
        end
    end

endmodule
